// File: rtl/pipe_read_bench_pkg.sv
// Shared encodings for the pipe-out read bench: pattern modes, FSM states, LFSR taps.
// LFSR taps are only consumed when PIPE_READ_BENCH_LFSR_EN is defined.
package pipe_read_bench_pkg;

   typedef enum logic [1:0] {
      PAT_COUNT = 2'd0,
      PAT_WALK  = 2'd1,
      PAT_FIXED = 2'd2,
      PAT_LFSR  = 2'd3
   } pattern_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Right-shifting Galois taps, maximal length for each width
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
   localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

   function automatic logic [63:0] lfsr_taps(input int unsigned width);
      if (width == 16)
         return {48'd0, LFSR_TAPS_16};
      else if (width == 64)
         return LFSR_TAPS_64;
      else
         return {32'd0, LFSR_TAPS_32};
   endfunction

endpackage

// File: rtl/bench_pattern_gen.sv
// Pattern generator: loads on run entry, steps once per accepted word.
// Mode 3 is a Galois LFSR only with PIPE_READ_BENCH_LFSR_EN; otherwise it counts.
module bench_pattern_gen
   import pipe_read_bench_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic                  i_advance,
   input  logic [1:0]            i_mode,
   input  logic [DATA_WIDTH-1:0] i_seed,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid
);

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
`ifdef PIPE_READ_BENCH_LFSR_EN
   localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
`endif

   pattern_e              r_mode;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   pattern_e              w_load_mode;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic [DATA_WIDTH-1:0] w_next_data;

   always_comb begin
      w_load_mode = pattern_e'(i_mode);
      w_load_data = i_seed;
      case (pattern_e'(i_mode))
         PAT_WALK: w_load_data = ONE;
`ifdef PIPE_READ_BENCH_LFSR_EN
         PAT_LFSR: if (i_seed == '0) w_load_data = ONE;
`else
         PAT_LFSR: w_load_mode = PAT_COUNT;
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_next_data = r_data;
      case (r_mode)
         PAT_COUNT: w_next_data = r_data + ONE;
         PAT_WALK:  w_next_data = {r_data[DATA_WIDTH-2:0], r_data[DATA_WIDTH-1]};
`ifdef PIPE_READ_BENCH_LFSR_EN
         PAT_LFSR:  w_next_data = {1'b0, r_data[DATA_WIDTH-1:1]} ^ (r_data[0] ? TAPS : '0);
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode  <= PAT_COUNT;
         r_data  <= i_seed;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_mode  <= w_load_mode;
         r_data  <= w_load_data;
         r_valid <= 1'b1;
      end else if (i_advance) begin
         r_data  <= w_next_data;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/pipe_read_bench.sv
// Read-throughput bench core: pattern generator -> FIFO -> block-throttled pipe-out.
// Optional LFSR pattern enabled by defining PIPE_READ_BENCH_LFSR_EN.
module pipe_read_bench
   import pipe_read_bench_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 1024,
   parameter int unsigned BLOCK_SIZE = 256,
   parameter int unsigned AF_MARGIN  = 4
) (
   input  logic                          okClk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          stop,
   input  logic [1:0]                    pattern_mode,
   input  logic [DATA_WIDTH-1:0]         pattern_seed,
   input  logic [31:0]                   word_limit,
   input  logic                          pipe_read,
   output logic [DATA_WIDTH-1:0]         pipe_data,
   output logic                          pipe_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic [63:0]                   clk_counts,
   output logic [31:0]                   words_sent,
   output logic                          busy,
   output logic                          done,
   output logic                          underflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] AF_LVL    = (AW+1)'(FIFO_DEPTH - AF_MARGIN);
   localparam logic [AW:0] BLOCK_LVL = (AW+1)'(BLOCK_SIZE);

   state_e                r_state;
   state_e                w_next_state;
   logic                  w_enter_run;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_fill;
   logic [DATA_WIDTH-1:0] r_pipe_data;
   logic [63:0]           r_clk_counts;
   logic [31:0]           r_words_sent;
   logic [31:0]           r_generated;
   logic                  r_underflow;

   logic                  w_busy;
   logic                  w_empty;
   logic                  w_limit_ok;
   logic                  w_wr;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_gen_data;
   logic                  w_gen_valid;

   assign w_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_empty    = (r_fill == '0);
   assign w_limit_ok = (word_limit == '0) || (r_generated < word_limit);

   // Stop outranks start everywhere; start is only honoured from IDLE/DONE
   always_comb begin
      w_next_state = r_state;
      w_enter_run  = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (!stop && start) begin
               w_next_state = ST_RUN;
               w_enter_run  = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop)
               w_next_state = ST_DONE;
            else if ((word_limit != '0) && (r_generated == word_limit))
               w_next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (stop || w_empty)
               w_next_state = ST_DONE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge okClk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   assign w_wr  = (r_state == ST_RUN) && w_gen_valid && w_limit_ok &&
                  (r_fill < AF_LVL) && (r_fill < FULL_LVL);
   assign w_pop = pipe_read && !w_empty && !w_enter_run;

   bench_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_gen (
      .clk       (okClk),
      .reset     (reset),
      .i_load    (w_enter_run),
      .i_advance (w_wr),
      .i_mode    (pattern_mode),
      .i_seed    (pattern_seed),
      .o_data    (w_gen_data),
      .o_valid   (w_gen_valid)
   );

   always_ff @(posedge okClk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= w_gen_data;
   end

   // Run entry flushes the FIFO and per-run statistics; pipe_data keeps its last word
   always_ff @(posedge okClk) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fill       <= '0;
         r_pipe_data  <= '0;
         r_clk_counts <= '0;
         r_words_sent <= '0;
         r_generated  <= '0;
         r_underflow  <= 1'b0;
      end else if (w_enter_run) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fill       <= '0;
         r_clk_counts <= '0;
         r_words_sent <= '0;
         r_generated  <= '0;
         r_underflow  <= 1'b0;
      end else begin
         if (w_busy)
            r_clk_counts <= r_clk_counts + 64'd1;
         if (w_wr) begin
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            r_generated <= r_generated + 32'd1;
         end
         if (w_pop) begin
            r_rd_ptr     <= r_rd_ptr + 1'b1;
            r_pipe_data  <= r_mem[r_rd_ptr];
            r_words_sent <= r_words_sent + 32'd1;
         end
         if (pipe_read && w_empty)
            r_underflow <= 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: ;
         endcase
      end
   end

   assign pipe_data  = r_pipe_data;
   assign pipe_ready = (r_fill >= BLOCK_LVL);
   assign fill_level = r_fill;
   assign clk_counts = r_clk_counts;
   assign words_sent = r_words_sent;
   assign busy       = w_busy;
   assign done       = (r_state == ST_DONE);
   assign underflow  = r_underflow;

endmodule

// File: tb/tb_pipe_read_bench.sv
// Scoreboard bench for pipe_read_bench: reads queue expected words, a monitor pops and compares.
// Mode-3 expectations follow PIPE_READ_BENCH_LFSR_EN.
module tb_pipe_read_bench;

   localparam int unsigned DW = 32;

   logic          okClk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop  = 1'b0;
   logic [1:0]    pattern_mode = 2'd0;
   logic [DW-1:0] pattern_seed = '0;
   logic [31:0]   word_limit = '0;
   logic          pipe_read = 1'b0;
   logic [DW-1:0] pipe_data;
   logic          pipe_ready;
   logic [10:0]   fill_level;
   logic [63:0]   clk_counts;
   logic [31:0]   words_sent;
   logic          busy;
   logic          done;
   logic          underflow;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   logic          rd_expect = 1'b0;
   logic          rd_pend = 1'b0;

   pipe_read_bench #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (1024),
      .BLOCK_SIZE (256),
      .AF_MARGIN  (4)
   ) dut (
      .okClk        (okClk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .pattern_mode (pattern_mode),
      .pattern_seed (pattern_seed),
      .word_limit   (word_limit),
      .pipe_read    (pipe_read),
      .pipe_data    (pipe_data),
      .pipe_ready   (pipe_ready),
      .fill_level   (fill_level),
      .clk_counts   (clk_counts),
      .words_sent   (words_sent),
      .busy         (busy),
      .done         (done),
      .underflow    (underflow)
   );

   always #5 okClk = ~okClk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: a tb-issued pop presents its word on the following negedge
   always @(posedge okClk) rd_pend <= pipe_read && rd_expect;

   always @(negedge okClk) begin
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_word", {32'd0, pipe_data}, 64'hDEAD_BEEF_0000_0000);
         end else begin
            chk("pipe_data", {32'd0, pipe_data}, {32'd0, exp_q.pop_front()});
         end
      end
   end

   function automatic bit cond(input int sel, input int unsigned tgt);
      case (sel)
         0:       return pipe_ready;
         1:       return done;
         default: return (fill_level == 11'(tgt));
      endcase
   endfunction

   task automatic wait_cond(input string nm, input int sel, input int unsigned tgt,
                            input int unsigned budget);
      int unsigned n = 0;
      while (!cond(sel, tgt) && n < budget) begin
         @(negedge okClk);
         n++;
      end
      chk(nm, {63'd0, cond(sel, tgt)}, 64'd1);
   endtask

   task automatic pulse(input logic s_start, input logic s_stop);
      start = s_start;
      stop  = s_stop;
      @(negedge okClk);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic read_word(input logic [DW-1:0] exp);
      exp_q.push_back(exp);
      pipe_read = 1'b1;
      rd_expect = 1'b1;
      @(negedge okClk);
      pipe_read = 1'b0;
      rd_expect = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pipe_data"},  {32'd0, pipe_data}, 64'd0);
      chk({tag, "_pipe_ready"}, {63'd0, pipe_ready}, 64'd0);
      chk({tag, "_fill"},       {53'd0, fill_level}, 64'd0);
      chk({tag, "_clk_counts"}, clk_counts, 64'd0);
      chk({tag, "_words_sent"}, {32'd0, words_sent}, 64'd0);
      chk({tag, "_busy"},       {63'd0, busy}, 64'd0);
      chk({tag, "_done"},       {63'd0, done}, 64'd0);
      chk({tag, "_underflow"},  {63'd0, underflow}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0]   c;
      logic [DW-1:0] v;

      repeat (3) @(negedge okClk);
      reset = 1'b0;
      chk_all_zero("reset");

      // start+stop together in IDLE: no run
      pulse(1'b1, 1'b1);
      repeat (2) @(negedge okClk);
      chk("idle_ss_busy", {63'd0, busy}, 64'd0);
      chk("idle_ss_done", {63'd0, done}, 64'd0);
      chk("idle_ss_fill", {53'd0, fill_level}, 64'd0);

      // COUNT from 0x10, 512 words in two blocks
      pattern_mode = 2'd0;
      pattern_seed = 32'h10;
      word_limit   = 32'd512;
      pulse(1'b1, 1'b0);
      for (int b = 0; b < 2; b++) begin
         wait_cond("a_ready_timeout", 0, 0, 600);
         for (int i = 0; i < 256; i++) read_word(32'h10 + 32'(b * 256 + i));
      end
      wait_cond("a_done_timeout", 1, 0, 50);
      chk("a_busy", {63'd0, busy}, 64'd0);
      chk("a_words_sent", {32'd0, words_sent}, 64'd512);
      chk("a_fill", {53'd0, fill_level}, 64'd0);
      chk("a_ready", {63'd0, pipe_ready}, 64'd0);

      // Stop 100 cycles into an unlimited run
      word_limit = 32'd0;
      pulse(1'b1, 1'b0);
      repeat (99) @(negedge okClk);
      pulse(1'b0, 1'b1);
      c = clk_counts;
      chk("b_done", {63'd0, done}, 64'd1);
      chk("b_busy", {63'd0, busy}, 64'd0);
      chk("b_cnt_range", {63'd0, (c >= 64'd99) && (c <= 64'd101)}, 64'd1);
      repeat (5) @(negedge okClk);
      chk("b_cnt_frozen", clk_counts, c);

      // Unlimited run with no reads: fill saturates at 1020, nothing lost
      pattern_seed = 32'h1000;
      pulse(1'b1, 1'b0);
      repeat (1100) @(negedge okClk);
      chk("d_fill_sat", {53'd0, fill_level}, 64'd1020);
      chk("d_ready", {63'd0, pipe_ready}, 64'd1);
      chk("d_busy", {63'd0, busy}, 64'd1);
      pulse(1'b0, 1'b1);
      chk("d_done", {63'd0, done}, 64'd1);
      for (int i = 0; i < 1020; i++) read_word(32'h1000 + 32'(i));
      repeat (2) @(negedge okClk);
      chk("d_fill_empty", {53'd0, fill_level}, 64'd0);
      chk("d_words_sent", {32'd0, words_sent}, 64'd1020);

      // Read from empty FIFO
      pipe_read = 1'b1;
      @(negedge okClk);
      pipe_read = 1'b0;
      @(negedge okClk);
      chk("u_underflow", {63'd0, underflow}, 64'd1);
      chk("u_data_held", {32'd0, pipe_data}, {32'd0, 32'h1000 + 32'd1019});
      chk("u_words_held", {32'd0, words_sent}, 64'd1020);

      // start+stop together in DONE: no run, underflow stays
      c = clk_counts;
      pulse(1'b1, 1'b1);
      @(negedge okClk);
      chk("ss_done", {63'd0, done}, 64'd1);
      chk("ss_busy", {63'd0, busy}, 64'd0);
      chk("ss_underflow", {63'd0, underflow}, 64'd1);
      chk("ss_cnt", clk_counts, c);

      // WALK, 64 words: new run clears underflow; tail never raises ready
      pattern_mode = 2'd1;
      pattern_seed = 32'hFFFF_0000;
      word_limit   = 32'd64;
      pulse(1'b1, 1'b0);
      chk("w_underflow_clr", {63'd0, underflow}, 64'd0);
      chk("w_busy", {63'd0, busy}, 64'd1);
      chk("w_words_clr", {32'd0, words_sent}, 64'd0);
      wait_cond("w_fill_timeout", 2, 64, 100);
      chk("w_tail_ready", {63'd0, pipe_ready}, 64'd0);
      for (int i = 0; i < 64; i++) begin
         v = 32'h1 << (i % 32);
         read_word(v);
      end
      wait_cond("w_done_timeout", 1, 0, 20);

      // Mode 3 with seed 0
      pattern_mode = 2'd3;
      pattern_seed = 32'h0;
      word_limit   = 32'd16;
      pulse(1'b1, 1'b0);
      wait_cond("l_fill_timeout", 2, 16, 50);
`ifdef PIPE_READ_BENCH_LFSR_EN
      v = 32'h1;
      for (int i = 0; i < 16; i++) begin
         read_word(v);
         v = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
      end
`else
      for (int i = 0; i < 16; i++) read_word(32'(i));
`endif
      wait_cond("l_done_timeout", 1, 0, 20);

      // Reset while draining
      pattern_mode = 2'd0;
      pattern_seed = 32'h55;
      word_limit   = 32'd8;
      pulse(1'b1, 1'b0);
      wait_cond("r_fill_timeout", 2, 8, 30);
      repeat (2) @(negedge okClk);
      chk("r_busy_drain", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      @(negedge okClk);
      chk_all_zero("r_mid");
      reset = 1'b0;

      repeat (3) @(negedge okClk);
      chk("sb_leftover", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
